// File: rtl/if_stage.sv
// RV32 instruction fetch stage: credit-limited word reads, an in-order response buffer
// with bypass into the decode output register, and flush-on-redirect that drops stale responses.
module if_stage #(
    parameter logic [31:0] ResetPC        = 32'h0000_0000,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iEn,
    input  logic        iStall,
    input  logic        iPCS_EXT,
    input  logic [31:0] iPC_EXT,
    output logic        oIMemReq,
    output logic [31:0] oIMemAddr,
    input  logic        iIMemReady,
    input  logic        iIMemValid,
    input  logic [31:0] iIMemData,
    output logic        oValid,
    output logic [31:0] oPC,
    output logic [31:0] oPC4,
    output logic [31:0] oINS,
    output logic        oMisalign
);

    localparam int PW = (MaxOutstanding > 32'd1) ? $clog2(MaxOutstanding) : 1;
    localparam int CW = $clog2(MaxOutstanding + 1);
    localparam int SW = CW + 1;
    localparam int DW = 8;
    localparam logic [31:0] Nop = 32'h0000_0013;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(MaxOutstanding - 1)) begin
            n = {PW{1'b0}};
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    logic [31:0]   fpc_r;
    logic [31:0]   ifq_mem_r [MaxOutstanding];
    logic [PW-1:0] ifq_rd_r;
    logic [PW-1:0] ifq_wr_r;
    logic [CW-1:0] ifq_cnt_r;
    logic [31:0]   buf_pc_r  [MaxOutstanding];
    logic [31:0]   buf_ins_r [MaxOutstanding];
    logic [PW-1:0] buf_rd_r;
    logic [PW-1:0] buf_wr_r;
    logic [CW-1:0] buf_cnt_r;
    logic [DW-1:0] discard_r;
    logic          valid_r;
    logic [31:0]   pc_r;
    logic [31:0]   ins_r;
    logic          misalign_r;

    logic redirect_s;
    logic credit_ok_s;
    logic req_s;
    logic req_fire_s;
    logic drop_s;
    logic pair_s;
    logic out_acc_s;
    logic buf_pop_s;
    logic bypass_s;
    logic buf_push_s;

    // Handshake strobes; a redirect overrides every buffer and output action.
    always_comb begin
        redirect_s  = iEn & iPCS_EXT;
        credit_ok_s = ({1'b0, ifq_cnt_r} + {1'b0, buf_cnt_r}) < SW'(MaxOutstanding);
        req_s       = iEn & ~iRst & ~iPCS_EXT & credit_ok_s;
        req_fire_s  = req_s & iIMemReady;
        drop_s      = iIMemValid & (discard_r != {DW{1'b0}});
        pair_s      = iIMemValid & (discard_r == {DW{1'b0}});
        out_acc_s   = iEn & (~valid_r | ~iStall);
        buf_pop_s   = ~redirect_s & out_acc_s & (buf_cnt_r != {CW{1'b0}});
        bypass_s    = ~redirect_s & out_acc_s & (buf_cnt_r == {CW{1'b0}}) & pair_s;
        buf_push_s  = ~redirect_s & pair_s & ~bypass_s;
    end

    // Queue storage; pointers alone define occupancy, so the arrays need no reset.
    always_ff @(posedge iClk) begin
        if (req_fire_s) begin
            ifq_mem_r[ifq_wr_r] <= fpc_r;
        end
        if (buf_push_s) begin
            buf_pc_r[buf_wr_r]  <= ifq_mem_r[ifq_rd_r];
            buf_ins_r[buf_wr_r] <= iIMemData;
        end
    end

    // Fetch PC, queue bookkeeping, discard counter and the decode output register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            fpc_r      <= ResetPC;
            ifq_rd_r   <= {PW{1'b0}};
            ifq_wr_r   <= {PW{1'b0}};
            ifq_cnt_r  <= {CW{1'b0}};
            buf_rd_r   <= {PW{1'b0}};
            buf_wr_r   <= {PW{1'b0}};
            buf_cnt_r  <= {CW{1'b0}};
            discard_r  <= {DW{1'b0}};
            valid_r    <= 1'b0;
            pc_r       <= 32'h0000_0000;
            ins_r      <= Nop;
            misalign_r <= 1'b0;
        end else if (redirect_s) begin
            fpc_r      <= {iPC_EXT[31:2], 2'b00};
            ifq_rd_r   <= {PW{1'b0}};
            ifq_wr_r   <= {PW{1'b0}};
            ifq_cnt_r  <= {CW{1'b0}};
            buf_rd_r   <= {PW{1'b0}};
            buf_wr_r   <= {PW{1'b0}};
            buf_cnt_r  <= {CW{1'b0}};
            // Remaining stale responses: pending discards plus in-flight reads not answered now.
            discard_r  <= discard_r - DW'(drop_s) + DW'(ifq_cnt_r) - DW'(pair_s);
            valid_r    <= 1'b0;
            ins_r      <= Nop;
            misalign_r <= (iPC_EXT[1:0] != 2'b00);
        end else begin
            misalign_r <= 1'b0;
            if (req_fire_s) begin
                fpc_r    <= fpc_r + 32'd4;
                ifq_wr_r <= ptr_inc(ifq_wr_r);
            end
            if (pair_s) begin
                ifq_rd_r <= ptr_inc(ifq_rd_r);
            end
            ifq_cnt_r <= ifq_cnt_r + CW'(req_fire_s) - CW'(pair_s);
            if (drop_s) begin
                discard_r <= discard_r - DW'(1);
            end
            if (buf_push_s) begin
                buf_wr_r <= ptr_inc(buf_wr_r);
            end
            if (buf_pop_s) begin
                buf_rd_r <= ptr_inc(buf_rd_r);
            end
            buf_cnt_r <= buf_cnt_r + CW'(buf_push_s) - CW'(buf_pop_s);
            if (out_acc_s) begin
                if (buf_pop_s) begin
                    valid_r <= 1'b1;
                    pc_r    <= buf_pc_r[buf_rd_r];
                    ins_r   <= buf_ins_r[buf_rd_r];
                end else if (bypass_s) begin
                    valid_r <= 1'b1;
                    pc_r    <= ifq_mem_r[ifq_rd_r];
                    ins_r   <= iIMemData;
                end else begin
                    valid_r <= 1'b0;
                    ins_r   <= Nop;
                end
            end
        end
    end

    assign oIMemReq  = req_s;
    assign oIMemAddr = fpc_r;
    assign oValid    = valid_r;
    assign oPC       = pc_r;
    assign oPC4      = pc_r + 32'd4;
    assign oINS      = ins_r;
    assign oMisalign = misalign_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: an in-order memory model with selectable latency returns
// each word address as its data, and each scenario task checks cycle-exact expectations.
module tb_if_stage;

    logic        iClk;
    logic        iRst;
    logic        iEn;
    logic        iStall;
    logic        iPCS_EXT;
    logic [31:0] iPC_EXT;
    logic        oIMemReq;
    logic [31:0] oIMemAddr;
    logic        iIMemReady;
    logic        iIMemValid;
    logic [31:0] iIMemData;
    logic        oValid;
    logic [31:0] oPC;
    logic [31:0] oPC4;
    logic [31:0] oINS;
    logic        oMisalign;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;
    int mem_cyc = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    if_stage #(.ResetPC(32'h0000_0100), .MaxOutstanding(2)) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iStall(iStall),
        .iPCS_EXT(iPCS_EXT), .iPC_EXT(iPC_EXT),
        .oIMemReq(oIMemReq), .oIMemAddr(oIMemAddr), .iIMemReady(iIMemReady),
        .iIMemValid(iIMemValid), .iIMemData(iIMemData),
        .oValid(oValid), .oPC(oPC), .oPC4(oPC4), .oINS(oINS), .oMisalign(oMisalign)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Memory response side: present the head response in the cycle it falls due.
    initial begin
        logic r;
        iIMemValid = 1'b0;
        iIMemData  = 32'hDEAD_BEEF;
        forever begin
            @(posedge iClk);
            r = iRst;
            #1;
            mem_cyc++;
            if (r === 1'b1) begin
                pend_addr.delete();
                pend_due.delete();
            end
            if (pend_due.size() > 0 && pend_due[0] == mem_cyc) begin
                iIMemValid = 1'b1;
                iIMemData  = pend_addr[0];
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                iIMemValid = 1'b0;
                iIMemData  = 32'hDEAD_BEEF;
            end
        end
    end

    // Memory request side: record accepted reads mid-cycle.
    initial begin
        forever begin
            @(negedge iClk);
            if (oIMemReq === 1'b1 && iIMemReady === 1'b1 && iRst === 1'b0) begin
                pend_addr.push_back(oIMemAddr);
                pend_due.push_back(mem_cyc + lat);
            end
        end
    end

    task automatic do_reset(input int l);
        @(posedge iClk);
        #1;
        iRst = 1'b1; iEn = 1'b1; iStall = 1'b0; iPCS_EXT = 1'b0;
        iPC_EXT = 32'h0; iIMemReady = 1'b1; lat = l;
        @(posedge iClk);
    endtask

    task automatic test_reset();
        do_reset(1);
        @(negedge iClk);
        n_tests++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b expected 0", oValid); end
        n_tests++; if (oPC !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h expected 00000000", oPC); end
        n_tests++; if (oPC4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc4 got %h expected 00000004", oPC4); end
        n_tests++; if (oINS !== 32'h13) begin n_fail++; $display("FAIL reset_ins got %h expected 00000013", oINS); end
        n_tests++; if (oIMemReq !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b expected 0", oIMemReq); end
        n_tests++; if (oMisalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %b expected 0", oMisalign); end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        for (int c = 0; c < 8; c++) begin
            @(posedge iClk); #1;
            iRst = 1'b0;
            @(negedge iClk);
            if (c == 0) begin
                n_tests++; if (oIMemReq !== 1'b1 || oIMemAddr !== 32'h100) begin n_fail++; $display("FAIL stream_first_req got %b/%h expected 1/00000100", oIMemReq, oIMemAddr); end
            end
            if (c < 2) begin
                n_tests++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid c=%0d got %b expected 0", c, oValid); end
            end else begin
                e = 32'h100 + 32'(4 * (c - 2));
                n_tests++; if (oValid !== 1'b1 || oPC !== e) begin n_fail++; $display("FAIL stream_pc c=%0d got %b/%h expected 1/%h", c, oValid, oPC, e); end
                n_tests++; if (oINS !== e || oPC4 !== e + 32'd4) begin n_fail++; $display("FAIL stream_ins c=%0d got %h/%h expected %h/%h", c, oINS, oPC4, e, e + 32'd4); end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        do_reset(1);
        for (int c = 0; c < 12; c++) begin
            @(posedge iClk); #1;
            iRst   = 1'b0;
            iStall = (c >= 4 && c <= 6);
            @(negedge iClk);
            if (c >= 2) begin
                if (c <= 4)      e = 32'h100 + 32'(4 * (c - 2));
                else if (c <= 7) e = 32'h108;
                else             e = 32'h10C + 32'(4 * (c - 8));
                n_tests++; if (oValid !== 1'b1 || oPC !== e || oINS !== e) begin n_fail++; $display("FAIL stall_out c=%0d got %b/%h/%h expected 1/%h/%h", c, oValid, oPC, oINS, e, e); end
            end
            if (c == 4) begin
                n_tests++; if (oIMemReq !== 1'b1 || oIMemAddr !== 32'h110) begin n_fail++; $display("FAIL stall_req4 got %b/%h expected 1/00000110", oIMemReq, oIMemAddr); end
            end
            if (c >= 5 && c <= 7) begin
                n_tests++; if (oIMemReq !== 1'b0) begin n_fail++; $display("FAIL stall_credit c=%0d got %b expected 0", c, oIMemReq); end
            end
            if (c == 8) begin
                n_tests++; if (oIMemReq !== 1'b1 || oIMemAddr !== 32'h114) begin n_fail++; $display("FAIL stall_resume_req got %b/%h expected 1/00000114", oIMemReq, oIMemAddr); end
            end
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset(3);
        for (int c = 0; c < 10; c++) begin
            @(posedge iClk); #1;
            iRst     = 1'b0;
            iPCS_EXT = (c == 2);
            iPC_EXT  = 32'h2000;
            @(negedge iClk);
            if (c == 2) begin
                n_tests++; if (oIMemReq !== 1'b0) begin n_fail++; $display("FAIL redir_req_in_r got %b expected 0", oIMemReq); end
            end
            if (c == 3) begin
                n_tests++; if (oIMemReq !== 1'b1 || oIMemAddr !== 32'h2000) begin n_fail++; $display("FAIL redir_target_req got %b/%h expected 1/00002000", oIMemReq, oIMemAddr); end
            end
            if (c <= 6 || c == 9) begin
                n_tests++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL redir_stale_valid c=%0d got %b/%h expected 0", c, oValid, oPC); end
            end
            if (c == 7) begin
                n_tests++; if (oValid !== 1'b1 || oPC !== 32'h2000 || oINS !== 32'h2000) begin n_fail++; $display("FAIL redir_first got %b/%h/%h expected 1/00002000/00002000", oValid, oPC, oINS); end
            end
            if (c == 8) begin
                n_tests++; if (oValid !== 1'b1 || oPC !== 32'h2004 || oINS !== 32'h2004) begin n_fail++; $display("FAIL redir_second got %b/%h/%h expected 1/00002004/00002004", oValid, oPC, oINS); end
            end
        end
    endtask

    task automatic test_misalign();
        do_reset(1);
        for (int c = 0; c < 9; c++) begin
            @(posedge iClk); #1;
            iRst     = 1'b0;
            iPCS_EXT = (c == 4);
            iPC_EXT  = 32'h2002;
            @(negedge iClk);
            if (c == 4 || c == 6) begin
                n_tests++; if (oMisalign !== 1'b0) begin n_fail++; $display("FAIL misalign_idle c=%0d got %b expected 0", c, oMisalign); end
            end
            if (c == 5) begin
                n_tests++; if (oMisalign !== 1'b1) begin n_fail++; $display("FAIL misalign_pulse got %b expected 1", oMisalign); end
                n_tests++; if (oValid !== 1'b0 || oIMemReq !== 1'b1 || oIMemAddr !== 32'h2000) begin n_fail++; $display("FAIL misalign_addr got %b/%b/%h expected 0/1/00002000", oValid, oIMemReq, oIMemAddr); end
            end
            if (c == 7) begin
                n_tests++; if (oValid !== 1'b1 || oPC !== 32'h2000 || oINS !== 32'h2000) begin n_fail++; $display("FAIL misalign_target got %b/%h/%h expected 1/00002000/00002000", oValid, oPC, oINS); end
            end
            if (c == 8) begin
                n_tests++; if (oValid !== 1'b1 || oPC !== 32'h2004) begin n_fail++; $display("FAIL misalign_next got %b/%h expected 1/00002004", oValid, oPC); end
            end
        end
    endtask

    task automatic test_stall_redirect();
        do_reset(1);
        for (int c = 0; c < 9; c++) begin
            @(posedge iClk); #1;
            iRst     = 1'b0;
            iStall   = (c == 4);
            iPCS_EXT = (c == 4);
            iPC_EXT  = 32'h3000;
            @(negedge iClk);
            if (c == 4) begin
                n_tests++; if (oValid !== 1'b1 || oPC !== 32'h108) begin n_fail++; $display("FAIL stredir_pre got %b/%h expected 1/00000108", oValid, oPC); end
            end
            if (c == 5 || c == 6) begin
                n_tests++; if (oValid !== 1'b0 || oINS !== 32'h13) begin n_fail++; $display("FAIL stredir_flush c=%0d got %b/%h expected 0/00000013", c, oValid, oINS); end
            end
            if (c == 7 || c == 8) begin
                n_tests++; if (oValid !== 1'b1 || oPC !== 32'h3000 + 32'(4 * (c - 7)) || oINS !== oPC) begin n_fail++; $display("FAIL stredir_target c=%0d got %b/%h/%h expected 1/%h", c, oValid, oPC, oINS, 32'h3000 + 32'(4 * (c - 7))); end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset(1);
        for (int c = 0; c < 8; c++) begin
            @(posedge iClk); #1;
            iRst     = 1'b0;
            iPCS_EXT = (c == 2);
            iPC_EXT  = 32'hFFFF_FFF8;
            @(negedge iClk);
            if (c == 4) begin
                n_tests++; if (oIMemReq !== 1'b1 || oIMemAddr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req_fffc got %b/%h expected 1/fffffffc", oIMemReq, oIMemAddr); end
            end
            if (c == 5) begin
                n_tests++; if (oIMemReq !== 1'b1 || oIMemAddr !== 32'h0) begin n_fail++; $display("FAIL wrap_req_zero got %b/%h expected 1/00000000", oIMemReq, oIMemAddr); end
            end
            if (c == 6) begin
                n_tests++; if (oValid !== 1'b1 || oPC !== 32'hFFFF_FFFC || oPC4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got %b/%h/%h expected 1/fffffffc/00000000", oValid, oPC, oPC4); end
            end
            if (c == 7) begin
                n_tests++; if (oValid !== 1'b1 || oPC !== 32'h0 || oPC4 !== 32'h4 || oINS !== 32'h0) begin n_fail++; $display("FAIL wrap_zero got %b/%h/%h/%h expected 1/0/4/0", oValid, oPC, oPC4, oINS); end
            end
        end
    endtask

    task automatic test_ready_enable();
        logic [31:0] e;
        do_reset(1);
        for (int c = 0; c < 12; c++) begin
            @(posedge iClk); #1;
            iRst       = 1'b0;
            iIMemReady = (c >= 3);
            iEn        = !(c == 7 || c == 8);
            iPCS_EXT   = (c == 7 || c == 8);
            iPC_EXT    = 32'h4001;
            @(negedge iClk);
            if (c <= 3) begin
                n_tests++; if (oIMemReq !== 1'b1 || oIMemAddr !== 32'h100 || oValid !== 1'b0) begin n_fail++; $display("FAIL ready_hold c=%0d got %b/%h/%b expected 1/00000100/0", c, oIMemReq, oIMemAddr, oValid); end
            end
            if (c >= 5) begin
                if (c <= 6)      e = 32'h100 + 32'(4 * (c - 5));
                else if (c <= 9) e = 32'h108;
                else             e = 32'h10C + 32'(4 * (c - 10));
                n_tests++; if (oValid !== 1'b1 || oPC !== e || oINS !== e) begin n_fail++; $display("FAIL en_out c=%0d got %b/%h/%h expected 1/%h", c, oValid, oPC, oINS, e); end
            end
            if (c == 7 || c == 8) begin
                n_tests++; if (oIMemReq !== 1'b0) begin n_fail++; $display("FAIL en_req_off c=%0d got %b expected 0", c, oIMemReq); end
            end
            if (c == 8 || c == 9) begin
                n_tests++; if (oMisalign !== 1'b0) begin n_fail++; $display("FAIL en_redirect_ignored c=%0d got %b expected 0", c, oMisalign); end
            end
            if (c == 9) begin
                n_tests++; if (oIMemReq !== 1'b1 || oIMemAddr !== 32'h110) begin n_fail++; $display("FAIL en_resume_req got %b/%h expected 1/00000110", oIMemReq, oIMemAddr); end
            end
        end
    endtask

    initial begin
        iRst = 1'b1; iEn = 1'b1; iStall = 1'b0; iPCS_EXT = 1'b0;
        iPC_EXT = 32'h0; iIMemReady = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_misalign();
        test_stall_redirect();
        test_wrap();
        test_ready_enable();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
